fetch_decode_fifo: RTL and testbench
====================================

// Module: fetch_decode_fifo
// PURPOSE
//  Multi-port in-order FIFO between fetch (writer) and decode (reader), carrying fetch_decode_pack_t.
//  Fetch pushes up to IN_WIDTH packs per cycle; decode sees up to OUT_WIDTH head entries and pops a prefix.
//  Commit-driven flush empties it in one cycle.
// PARAMETERS
//  DEPTH      16              entries; power of 2, >= max(IN_WIDTH, OUT_WIDTH)
//  IN_WIDTH   `FETCH_WIDTH    push ports
//  OUT_WIDTH  `DECODE_WIDTH   pop ports
// PORTS
//  clk                               in   1                  clock
//  rst                               in   1                  synchronous reset, active-high
//  fetch_decode_fifo_data_in_enable  out  IN_WIDTH           bit i = 1 iff free slots > i
//  fetch_decode_fifo_data_in         in   IN_WIDTH x pack    push data, lane 0 oldest
//  fetch_decode_fifo_data_in_valid   in   IN_WIDTH           lanes to write; contiguous prefix from bit 0
//  fetch_decode_fifo_push            in   1                  push strobe
//  fetch_decode_fifo_data_out        out  OUT_WIDTH x pack   entry at head+i; 'b0 when lane invalid
//  fetch_decode_fifo_data_out_valid  out  OUT_WIDTH          bit i = 1 iff count > i
//  fetch_decode_fifo_data_pop_valid  in   OUT_WIDTH          lanes consumed; contiguous prefix
//  fetch_decode_fifo_pop             in   1                  pop strobe
//  fetch_decode_fifo_flush           in   1                  discard all entries
//  fetch_decode_fifo_full            out  1                  count == DEPTH
// BEHAVIOUR
//  - State: storage[DEPTH], rptr/wptr of $clog2(DEPTH)+1 bits (wrap bit).
//    count = wptr - rptr; full = (count == DEPTH); empty = (count == 0).
//  - All outputs are functions of registered state only; no fall-through, no same-cycle bypass.
//    Data pushed in cycle N is visible on data_out in cycle N+1.
//  - Push (push && !flush && !rst):
//    n = popcount(data_in_valid & data_in_enable);
//    lanes 0..n-1 are written to storage[(wptr+k) mod DEPTH];
//    wptr += n.
//  - Pop (pop && !flush && !rst):
//    m = popcount(data_pop_valid & data_out_valid);
//    rptr += m.
//  - Simultaneous push and pop: both apply in the same cycle.
//    data_in_enable reflects pre-pop free space, so slots freed by a pop are offered the next cycle.
//    Count never exceeds DEPTH and never underflows.
//  - Masked-off bits: valid bits outside enable, and pop bits outside out_valid, are ignored (no effect).
//    A non-prefix valid/pop mask is a protocol error; flagged by a bench assertion only.
//  - Wrap-around: pointers are modulo 2*DEPTH; storage index = ptr[$clog2(DEPTH)-1:0].
//    Multi-lane reads and writes crossing the array end are handled.
//  - Flush: rptr = wptr = 0 next cycle; push and pop in the flush cycle are ignored; storage is not cleared.
//  - Reset: same as flush, taking priority over everything.
//    Output values after reset:
//      data_out_valid = 0
//      data_out = 0
//      data_in_enable = all ones
//      full = 0
//    Reset asserted mid-operation drops all entries.
// CONFIGURATION
//  FETCH_DECODE_FIFO_FULL_ADD_EN:
//    Defined: adds output fetch_decode_fifo_full_add (1 bit, registered, reset 0).
//      It is 1 in cycle N+1 iff, in cycle N, full was 1 and a push with a nonzero valid mask was refused.
//      Used to drive the CSR stall performance counter.
//    Undefined: the port and its logic are absent; all other behaviour is unchanged.
// TESTING  (DEPTH=4, IN_WIDTH=OUT_WIDTH=2)
//  1. Reset, then idle.
//     -> out_valid=00, in_enable=11, full=0.
//  2. Push valid=11 {A,B}, then idle.
//     -> next cycle: out_valid=11, out[0]=A, out[1]=B, in_enable=11.
//  3. Push {A,B} and {C,D}.
//     -> full=1, in_enable=00.
//     Then pop=01 together with a push of {E,F}.
//     -> E,F dropped; out={B,C}; in_enable=01.
//  4. Run a steady stream of push 2 and pop 2 for 10 cycles.
//     -> in-order data across the pointer wrap; count stays constant; no loss.
//  5. Hold 3 entries, then assert flush together with push=11 and pop=11.
//     -> next cycle: out_valid=00, in_enable=11.
//  6. With FULL_ADD_EN: hold full and push=11.
//     -> full_add=1 next cycle.
//     Full with no push -> full_add=0.

Source files
------------

// File: rtl/fetch_decode_fifo.sv
// Multi-port in-order FIFO between fetch and decode. Optional stall-event output is enabled
// by defining FETCH_DECODE_FIFO_FULL_ADD_EN.
module fetch_decode_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IN_WIDTH   = 2,
  parameter int unsigned OUT_WIDTH  = 2,
  parameter int unsigned PACK_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [IN_WIDTH-1:0]              fetch_decode_fifo_data_in_enable,
  input  logic [IN_WIDTH*PACK_WIDTH-1:0]   fetch_decode_fifo_data_in,
  input  logic [IN_WIDTH-1:0]              fetch_decode_fifo_data_in_valid,
  input  logic                             fetch_decode_fifo_push,
  output logic [OUT_WIDTH*PACK_WIDTH-1:0]  fetch_decode_fifo_data_out,
  output logic [OUT_WIDTH-1:0]             fetch_decode_fifo_data_out_valid,
  input  logic [OUT_WIDTH-1:0]             fetch_decode_fifo_data_pop_valid,
  input  logic                             fetch_decode_fifo_pop,
  input  logic                             fetch_decode_fifo_flush,
  output logic                             fetch_decode_fifo_full
`ifdef FETCH_DECODE_FIFO_FULL_ADD_EN
  ,
  output logic                             fetch_decode_fifo_full_add
`endif
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;
  localparam logic [PtrW-1:0] DepthP = PtrW'(DEPTH);

  logic [PACK_WIDTH-1:0] storage_q [DEPTH];
  logic [PtrW-1:0]       rptr_q, wptr_q;
  logic [PtrW-1:0]       count, free, n_push, n_pop;
  logic [IN_WIDTH-1:0]   wr_mask;
  logic [OUT_WIDTH-1:0]  rd_mask;
  logic                  do_push, do_pop;

  assign do_push = fetch_decode_fifo_push && !fetch_decode_fifo_flush && !rst;
  assign do_pop  = fetch_decode_fifo_pop && !fetch_decode_fifo_flush && !rst;

  always_comb begin
    count = wptr_q - rptr_q;
    free  = DepthP - count;
    fetch_decode_fifo_full = (count == DepthP);
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      fetch_decode_fifo_data_in_enable[i] = (free > PtrW'(i));
    end
    for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
      fetch_decode_fifo_data_out_valid[i] = (count > PtrW'(i));
      fetch_decode_fifo_data_out[i*PACK_WIDTH +: PACK_WIDTH] =
          fetch_decode_fifo_data_out_valid[i] ? storage_q[IdxW'(rptr_q + PtrW'(i))]
                                              : '0;
    end
    // Masked-off lanes are ignored, so counts come from the masks ANDed with availability.
    wr_mask = fetch_decode_fifo_data_in_valid & fetch_decode_fifo_data_in_enable;
    rd_mask = fetch_decode_fifo_data_pop_valid & fetch_decode_fifo_data_out_valid;
    n_push  = '0;
    n_pop   = '0;
    for (int unsigned k = 0; k < IN_WIDTH; k++) begin
      n_push = n_push + PtrW'(wr_mask[k]);
    end
    for (int unsigned k = 0; k < OUT_WIDTH; k++) begin
      n_pop = n_pop + PtrW'(rd_mask[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || fetch_decode_fifo_flush) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + n_push;
      if (do_pop)  rptr_q <= rptr_q + n_pop;
    end
  end

  // Storage is never cleared; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      for (int unsigned k = 0; k < IN_WIDTH; k++) begin
        if (PtrW'(k) < n_push) begin
          storage_q[IdxW'(wptr_q + PtrW'(k))] <=
              fetch_decode_fifo_data_in[k*PACK_WIDTH +: PACK_WIDTH];
        end
      end
    end
  end

`ifdef FETCH_DECODE_FIFO_FULL_ADD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_decode_fifo_full_add <= 1'b0;
    end else begin
      fetch_decode_fifo_full_add <= fetch_decode_fifo_full && do_push &&
                                    (|fetch_decode_fifo_data_in_valid);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_fifo.sv
// Randomized self-checking bench for fetch_decode_fifo against a queue-based reference model.
module tb_fetch_decode_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 2;
  localparam int unsigned OW    = 2;
  localparam int unsigned PW    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [IW-1:0]     in_enable;
  logic [IW*PW-1:0]  data_in;
  logic [IW-1:0]     in_valid;
  logic              push;
  logic [OW*PW-1:0]  data_out;
  logic [OW-1:0]     out_valid;
  logic [OW-1:0]     pop_valid;
  logic              pop;
  logic              flush;
  logic              full;
`ifdef FETCH_DECODE_FIFO_FULL_ADD_EN
  logic              full_add;
`endif

  int unsigned       n_checks = 0;
  int unsigned       n_pass = 0;
  logic [PW-1:0]     model_q[$];
  logic              exp_full_add = 1'b0;

  always #5 clk = ~clk;

  fetch_decode_fifo #(
    .DEPTH     (DEPTH),
    .IN_WIDTH  (IW),
    .OUT_WIDTH (OW),
    .PACK_WIDTH(PW)
  ) dut (
    .clk                             (clk),
    .rst                             (rst),
    .fetch_decode_fifo_data_in_enable(in_enable),
    .fetch_decode_fifo_data_in       (data_in),
    .fetch_decode_fifo_data_in_valid (in_valid),
    .fetch_decode_fifo_push          (push),
    .fetch_decode_fifo_data_out      (data_out),
    .fetch_decode_fifo_data_out_valid(out_valid),
    .fetch_decode_fifo_data_pop_valid(pop_valid),
    .fetch_decode_fifo_pop           (pop),
    .fetch_decode_fifo_flush         (flush),
    .fetch_decode_fifo_full          (full)
`ifdef FETCH_DECODE_FIFO_FULL_ADD_EN
    ,
    .fetch_decode_fifo_full_add      (full_add)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    logic [OW-1:0] ev;
    logic [IW-1:0] ie;
    int unsigned   sz;
    sz = model_q.size();
    for (int i = 0; i < OW; i++) ev[i] = (sz > i);
    for (int i = 0; i < IW; i++) ie[i] = ((DEPTH - sz) > i);
    check("out_valid", 32'(out_valid), 32'(ev));
    check("in_enable", 32'(in_enable), 32'(ie));
    check("full", 32'(full), 32'(sz == DEPTH));
    for (int i = 0; i < OW; i++) begin
      check($sformatf("data_out[%0d]", i), 32'(data_out[i*PW +: PW]),
            (sz > i) ? 32'(model_q[i]) : 32'd0);
    end
`ifdef FETCH_DECODE_FIFO_FULL_ADD_EN
    check("full_add", 32'(full_add), 32'(exp_full_add));
`endif
  endtask

  // One clock cycle: drive inputs, advance the model by the FIFO rules, then compare.
  task automatic step(input logic p, input logic [IW-1:0] v, input logic [IW*PW-1:0] d,
                      input logic po, input logic [OW-1:0] pv, input logic fl, input logic r);
    int unsigned sz;
    int unsigned n;
    int unsigned m;
    assert (((v & (v + 1'b1)) == 0) && ((pv & (pv + 1'b1)) == 0))
      else $error("non-prefix valid/pop mask driven");
    push = p; in_valid = v; data_in = d; pop = po; pop_valid = pv; flush = fl; rst = r;
    @(posedge clk);
    sz = model_q.size();
    exp_full_add = (sz == DEPTH) && p && (|v) && !fl && !r;
    if (r || fl) begin
      model_q.delete();
    end else begin
      n = 0;
      m = 0;
      if (p) for (int k = 0; k < IW; k++) if (v[k] && (DEPTH - sz) > k) n++;
      if (po) for (int k = 0; k < OW; k++) if (pv[k] && sz > k) m++;
      repeat (m) void'(model_q.pop_front());
      for (int k = 0; k < n; k++) model_q.push_back(d[k*PW +: PW]);
    end
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [IW-1:0]    v;
    logic [OW-1:0]    pv;
    logic [IW*PW-1:0] d;
    int unsigned      seq;

    step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_enable", 32'(in_enable), 32'd3);

    // Two-lane push becomes visible on the next cycle.
    step(1'b1, 2'b11, {16'h000B, 16'h000A}, 1'b0, '0, 1'b0, 1'b0);
    check("push2_lane0", 32'(data_out[PW-1:0]), 32'h000A);
    check("push2_lane1", 32'(data_out[2*PW-1:PW]), 32'h000B);
    idle();

    // Fill, then a refused push alongside a single pop.
    step(1'b1, 2'b11, {16'h000D, 16'h000C}, 1'b0, '0, 1'b0, 1'b0);
    check("fill_full", 32'(full), 32'd1);
    step(1'b1, 2'b11, {16'h000F, 16'h000E}, 1'b1, 2'b01, 1'b0, 1'b0);
    check("pop1_lane0", 32'(data_out[PW-1:0]), 32'h000B);
    check("pop1_in_enable", 32'(in_enable), 32'd1);

    // Steady stream of push 2 / pop 2 across the pointer wrap.
    step(1'b0, '0, '0, 1'b1, 2'b01, 1'b0, 1'b0);
    seq = 16'h100;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 2'b11, {16'(seq + 1), 16'(seq)}, 1'b1, 2'b11, 1'b0, 1'b0);
      seq += 2;
      check("stream_count", 32'(out_valid), 32'd3);
    end

    // Flush with 3 entries while push and pop are also requested.
    step(1'b1, 2'b01, {16'h0, 16'h0777}, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 2'b11, {16'h0999, 16'h0888}, 1'b1, 2'b11, 1'b1, 1'b0);
    check("flush_out_valid", 32'(out_valid), 32'd0);

    // Hold full and keep pushing to exercise the stall event.
    step(1'b1, 2'b11, {16'h0002, 16'h0001}, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 2'b11, {16'h0004, 16'h0003}, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 2'b11, {16'h0006, 16'h0005}, 1'b0, '0, 1'b0, 1'b0);
    idle();

    for (int c = 0; c < 400; c++) begin
      v  = IW'((1 << $urandom_range(0, IW)) - 1);
      pv = OW'((1 << $urandom_range(0, OW)) - 1);
      d  = {16'($urandom), 16'($urandom)};
      step(($urandom % 4) != 0, v, d, ($urandom % 3) != 0, pv,
           ($urandom % 25) == 0, ($urandom % 60) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
